// File: rtl/crc_field_controller_if.sv
// crc_field_controller_if: front-end strobes and CRC datapath signals of the CRC field controller
//   front end -> controller : sample_point, rx_bit, is_stuff, frame_start, fd_frame, dlc, dlc_valid, data_end, abort
//   datapath  -> controller : crc_value
//   controller -> datapath / error logic : crc_init, crc_on, crc_sel, crc_field, crc_done, crc_ok, crc_error
interface crc_field_controller_if;
    logic        sample_point, rx_bit, is_stuff, frame_start, fd_frame, dlc_valid, data_end, abort;
    logic [3:0]  dlc;
    logic [20:0] crc_value;
    logic        crc_init, crc_on, crc_field, crc_done, crc_ok, crc_error;
    logic [1:0]  crc_sel;
    modport master (
        output sample_point, rx_bit, is_stuff, frame_start, fd_frame, dlc, dlc_valid, data_end, abort, crc_value,
        input  crc_init, crc_on, crc_sel, crc_field, crc_done, crc_ok, crc_error
    );
    modport slave (
        input  sample_point, rx_bit, is_stuff, frame_start, fd_frame, dlc, dlc_valid, data_end, abort, crc_value,
        output crc_init, crc_on, crc_sel, crc_field, crc_done, crc_ok, crc_error
    );
endinterface

// File: rtl/crc_field_controller.sv
// crc_field_controller: sequences the CAN/CAN FD CRC datapath from SOF to the end of the CRC field
//   clk       : system clock
//   reset     : asynchronous, active-high
//   bus.slave : destuffed bit stream and frame events in, crc_value from the datapath;
//               crc_init/crc_on/crc_sel to the datapath, crc_field/crc_done/crc_ok/crc_error out
module crc_field_controller #(
    parameter int CLASSIC_LEN      = 15,
    parameter int FD_SHORT_LEN     = 17,
    parameter int FD_LONG_LEN      = 21,
    parameter int FD_SHORT_MAX_DLC = 10
) (
    input logic clk,
    input logic reset,
    crc_field_controller_if.slave bus
);
    typedef enum logic [2:0] {IDLE, CALC, LATCH, FIELD, DONE} state_t;
    state_t      state, state_nx;
    logic [1:0]  sel;
    logic [20:0] exp_crc;
    logic [4:0]  cnt, len;
    logic        flag, err, take, mm, last;
    // received bits arrive MSB first, so the counter doubles as the expected-bit index
    assign take = state == FIELD && bus.sample_point && !bus.is_stuff;
    assign mm   = bus.rx_bit ^ exp_crc[cnt - 5'd1];
    assign last = take && cnt == 5'd1;
    assign len  = sel == 2'd1 ? 5'(CLASSIC_LEN) : sel == 2'd2 ? 5'(FD_SHORT_LEN) : 5'(FD_LONG_LEN);
    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else state <= state_nx;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = bus.sample_point && bus.frame_start ? CALC : IDLE;
            CALC:    state_nx = bus.sample_point && bus.data_end ? LATCH : CALC;
            LATCH:   state_nx = sel == 2'd0 ? DONE : FIELD;
            FIELD:   state_nx = last ? DONE : FIELD;
            default: state_nx = IDLE;
        endcase
        if (bus.abort) state_nx = IDLE;
        // reset is folded in so every output is 0 while reset is held
        bus.crc_init  = !reset && state == IDLE && bus.sample_point && bus.frame_start && !bus.abort;
        bus.crc_on    = state == CALC;
        bus.crc_sel   = state == CALC || state == LATCH || state == FIELD ? sel : 2'd0;
        bus.crc_field = state == FIELD;
        bus.crc_done  = state == DONE;
        bus.crc_error = state == DONE && err;
        bus.crc_ok    = state == DONE && !err;
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            sel     <= 2'd0;
            exp_crc <= 21'd0;
            cnt     <= 5'd0;
            flag    <= 1'b0;
            err     <= 1'b0;
        end else if (bus.abort) begin
            sel <= 2'd0;
        end else begin
            case (state)
                IDLE: if (bus.sample_point && bus.frame_start) sel <= 2'd0;
                // sel == 0 marks "no DLC yet", so only the first dlc_valid selects the polynomial
                CALC: if (bus.sample_point && bus.dlc_valid && sel == 2'd0)
                    sel <= !bus.fd_frame ? 2'd1 : int'(bus.dlc) <= FD_SHORT_MAX_DLC ? 2'd2 : 2'd3;
                LATCH: begin
                    exp_crc <= bus.crc_value;
                    cnt     <= len;
                    flag    <= 1'b0;
                    err     <= sel == 2'd0;
                end
                FIELD: if (take) begin
                    cnt  <= cnt - 5'd1;
                    flag <= flag | mm;
                    if (cnt == 5'd1) err <= flag | mm;
                end
                default: ;
            endcase
        end
endmodule

// File: tb/tb_crc_field_controller.sv
// tb_crc_field_controller: directed frame vectors and corner sequences for crc_field_controller
module tb_crc_field_controller;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    crc_field_controller_if bus();
    crc_field_controller dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    typedef struct {
        logic        fd;
        logic [3:0]  dlc;
        logic        give_dlc;
        logic [20:0] crc;
        logic [20:0] rx;
        int          len;
        logic [39:0] stuff;
        int          cut;
        int          cut_at;
        logic [1:0]  exp_sel;
        int          exp_bits;
        logic        exp_err;
    } vec_t;
    vec_t vecs[12];
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic strobe(input logic fs, dv, de, rb, st, ab);
        bus.sample_point = 1'b1;
        bus.frame_start  = fs;
        bus.dlc_valid    = dv;
        bus.data_end     = de;
        bus.rx_bit       = rb;
        bus.is_stuff     = st;
        bus.abort        = ab;
        @(negedge clk);
        bus.sample_point = 1'b0;
        bus.frame_start  = 1'b0;
        bus.dlc_valid    = 1'b0;
        bus.data_end     = 1'b0;
        bus.is_stuff     = 1'b0;
        bus.abort        = 1'b0;
        #1;
    endtask
    function automatic logic [9:0] outs();
        return {bus.crc_init, bus.crc_on, bus.crc_sel, bus.crc_field, bus.crc_done, bus.crc_ok, bus.crc_error, 2'b00};
    endfunction
    task automatic run_frame(input vec_t v);
        int   n, slot, k;
        logic field_seen, ab, b;
        bus.fd_frame  = v.fd;
        bus.dlc       = v.dlc;
        bus.crc_value = v.crc;
        bus.sample_point = 1'b1;
        bus.frame_start  = 1'b1;
        #1;
        chk("sof_init", bus.crc_init, 1);
        chk("sof_on", bus.crc_on, 0);
        @(negedge clk);
        bus.sample_point = 1'b0;
        bus.frame_start  = 1'b0;
        #1;
        chk("sof_init_pulse", bus.crc_init, 0);
        chk("calc_on", bus.crc_on, 1);
        for (int i = 0; i < 2; i++) strobe(0, 0, 0, 1'($urandom), 0, 0);
        if (v.give_dlc) begin
            strobe(0, 1, 0, 0, 0, 0);
            bus.dlc = 4'd0;
            strobe(0, 1, 0, 0, 0, 0);
        end
        strobe(0, 0, 0, 1'($urandom), 0, 0);
        strobe(0, 0, 1, 0, 0, 0);
        chk("latch_on", bus.crc_on, 0);
        chk("sel", bus.crc_sel, v.exp_sel);
        @(negedge clk);
        bus.crc_value = ~v.crc;
        n = 0;
        slot = 0;
        field_seen = 1'b0;
        while (!bus.crc_done && slot < 40) begin
            field_seen |= bus.crc_field;
            if (v.stuff[slot]) strobe(0, 0, 0, 1'($urandom), 1, 0);
            else begin
                k  = v.len - 1 - n;
                b  = k >= 0 ? v.rx[k] : 1'b0;
                ab = v.cut == 1 && n + 1 == v.cut_at;
                strobe(0, 0, 0, b, 0, ab);
                n++;
                if (ab) begin
                    chk("abort_idle", {bus.crc_on, bus.crc_field, bus.crc_sel, bus.crc_done}, 0);
                    for (int i = 0; i < 3; i++) begin
                        @(negedge clk);
                        chk("abort_no_done", bus.crc_done, 0);
                    end
                    return;
                end
                if (v.cut == 2 && n == v.cut_at) begin
                    chk("pre_reset_field", bus.crc_field, 1);
                    #2 reset = 1'b1;
                    #1 chk("async_reset_outs", outs(), 0);
                    @(negedge clk);
                    reset = 1'b0;
                    @(negedge clk);
                    return;
                end
            end
            slot++;
            if (!bus.crc_done) @(negedge clk);
        end
        chk("done", bus.crc_done, 1);
        chk("bits", n, v.exp_bits);
        chk("err", bus.crc_error, v.exp_err);
        chk("ok", bus.crc_ok, !v.exp_err);
        chk("field_seen", field_seen, v.exp_bits > 0);
        @(negedge clk);
        chk("done_pulse", bus.crc_done, 0);
        @(negedge clk);
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1);
    end
    initial begin
        //        fd    dlc    dlc   crc          rx          len stuff          cut at sel   bits err
        vecs[0]  = '{1'b0, 4'd8,  1'b1, 21'h004B3A, 21'h004B3A, 15, 40'h820,       0, 0,  2'd1, 15, 1'b0};
        vecs[1]  = '{1'b1, 4'd10, 1'b1, 21'h01F0F0, 21'h01F0F0, 17, 40'h1111,      0, 0,  2'd2, 17, 1'b0};
        vecs[2]  = '{1'b1, 4'd11, 1'b1, 21'h012345, 21'h012345, 21, 40'h0,         0, 0,  2'd3, 21, 1'b0};
        vecs[3]  = '{1'b1, 4'd15, 1'b1, 21'h155555, 21'h155555, 21, 40'h100,       0, 0,  2'd3, 21, 1'b0};
        vecs[4]  = '{1'b1, 4'd12, 1'b1, 21'h1ABCDE, 21'h0ABCDE, 21, 40'h2108421,   0, 0,  2'd3, 21, 1'b1};
        vecs[5]  = '{1'b0, 4'd3,  1'b1, 21'h1F4B3A, 21'h004B3A, 15, 40'h0,         0, 0,  2'd1, 15, 1'b0};
        vecs[6]  = '{1'b0, 4'd8,  1'b1, 21'h004B3A, 21'h004B3B, 15, 40'h0,         0, 0,  2'd1, 15, 1'b1};
        vecs[7]  = '{1'b0, 4'd8,  1'b0, 21'h004B3A, 21'h004B3A, 15, 40'h0,         0, 0,  2'd0, 0,  1'b1};
        vecs[8]  = '{1'b1, 4'd0,  1'b1, 21'h000001, 21'h000101, 17, 40'h0,         0, 0,  2'd2, 17, 1'b1};
        vecs[9]  = '{1'b0, 4'd8,  1'b1, 21'h004B3A, 21'h004B3A, 15, 40'h0,         1, 10, 2'd1, 0,  1'b0};
        vecs[10] = '{1'b1, 4'd11, 1'b1, 21'h1ABCDE, 21'h1ABCDE, 21, 40'h0,         2, 5,  2'd3, 0,  1'b0};
        vecs[11] = '{1'b0, 4'd8,  1'b1, 21'h004B3A, 21'h004B3A, 15, 40'h820,       0, 0,  2'd1, 15, 1'b0};
        bus.sample_point = 1'b0;
        bus.rx_bit       = 1'b0;
        bus.is_stuff     = 1'b0;
        bus.frame_start  = 1'b0;
        bus.fd_frame     = 1'b0;
        bus.dlc          = 4'd0;
        bus.dlc_valid    = 1'b0;
        bus.data_end     = 1'b0;
        bus.abort        = 1'b0;
        bus.crc_value    = 21'd0;
        repeat (3) @(negedge clk);
        chk("reset_outs", outs(), 0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_outs", outs(), 0);
        for (int i = 0; i < 12; i++) run_frame(vecs[i]);
        bus.fd_frame = 1'b0;
        bus.dlc      = 4'd8;
        strobe(1, 0, 0, 0, 0, 0);
        strobe(0, 1, 0, 0, 0, 0);
        bus.sample_point = 1'b1;
        bus.frame_start  = 1'b1;
        #1 chk("sof_in_calc_ignored", bus.crc_init, 0);
        @(negedge clk);
        bus.sample_point = 1'b0;
        bus.frame_start  = 1'b0;
        #1 chk("still_calc", {bus.crc_on, bus.crc_sel}, 3'b101);
        strobe(0, 0, 1, 0, 0, 1);
        chk("abort_data_end", {bus.crc_on, bus.crc_sel, bus.crc_field, bus.crc_done}, 0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("abort_data_end_quiet", {bus.crc_field, bus.crc_done}, 0);
        end
        run_frame(vecs[0]);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/crc_field_controller.md
Name: crc_field_controller

Overview:
Sequences the CAN/CAN FD CRC datapath for one frame, from SOF through the end of the CRC field.
- Clears and enables the shared CRC datapath at SOF.
- Selects CRC-15, CRC-17 or CRC-21 from the FDF bit and DLC.
- Snapshots the computed CRC after the last data bit.
- Compares the received CRC field bit by bit, excluding stuff bits.
- Reports crc_ok or crc_error to the error-handling logic.
- Sits between the bit-timing/destuff front end and the CRC datapath.

Parameters:
CLASSIC_LEN, 15, CRC field length for classic frames
FD_SHORT_LEN, 17, CRC length for FD frames with DLC <= FD_SHORT_MAX_DLC
FD_LONG_LEN, 21, CRC length for FD frames with DLC > FD_SHORT_MAX_DLC
FD_SHORT_MAX_DLC, 10, largest DLC (16 bytes) that uses CRC-17

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high
sample_point  in  1  one-clk strobe; bus bit sampled this cycle
rx_bit  in  1  destuffed-stream bit valid with sample_point
is_stuff  in  1  current sampled bit is a stuff bit (dynamic or FD fixed)
frame_start  in  1  SOF sampled (qualified by sample_point)
fd_frame  in  1  FDF bit value, stable once dlc_valid
dlc  in  4  data length code
dlc_valid  in  1  DLC fully received (qualified by sample_point)
data_end  in  1  last data bit sampled (qualified by sample_point)
abort  in  1  error/overload frame start; cancel frame
crc_value  in  21  datapath CRC for current crc_sel, right-aligned
crc_init  out  1  one-clk pulse: clear datapath CRC registers
crc_on  out  1  datapath accumulate enable
crc_sel  out  2  0 none, 1 CRC-15, 2 CRC-17, 3 CRC-21
crc_field  out  1  controller is in the CRC field
crc_done  out  1  one-clk pulse: check complete
crc_ok  out  1  valid with crc_done: CRC matched
crc_error  out  1  valid with crc_done: mismatch or sequencing fault

Behaviour:
Reset: every output is 0. The state is IDLE, and the bit counter, snapshot register and mismatch flag are cleared. Reset mid-frame takes effect immediately.

States: IDLE, CALC, LATCH, FIELD, DONE.

IDLE:
- frame_start & sample_point: pulse crc_init for the same clk, set crc_on=1 from the next clk, clear crc_sel, go to CALC.

CALC:
- crc_on=1.
- First dlc_valid & sample_point latches crc_sel:
  - fd_frame=0: crc_sel=1.
  - fd_frame=1 and dlc <= FD_SHORT_MAX_DLC: crc_sel=2.
  - otherwise: crc_sel=3.
- Later dlc_valid pulses are ignored.
- data_end & sample_point: go to LATCH; crc_on drops to 0 the next clk.

LATCH (exactly 1 clk):
- Snapshot crc_value into the expected register; load the bit counter with the length for crc_sel; clear the mismatch flag; go to FIELD.
- If crc_sel=0 (DLC never seen): skip FIELD; pulse crc_done with crc_error=1, crc_ok=0; go to DONE.

FIELD:
- crc_field=1.
- On each sample_point with is_stuff=0:
  - compare rx_bit with expected[cnt-1] (MSB first);
  - OR any mismatch into the sticky flag;
  - decrement cnt.
- Bits with is_stuff=1 are neither compared nor counted.
- When cnt goes 1->0: pulse crc_done on the next clk with crc_error = flag | last-bit mismatch and crc_ok = its inverse; go to DONE.

DONE:
- Outputs return to 0; go to IDLE the next clk.

abort:
- Any state goes to IDLE on the next clk.
- crc_on, crc_field and crc_sel clear; no crc_done pulse.
- abort wins over a simultaneous data_end or last CRC bit.

Other event rules:
- frame_start outside IDLE is ignored.
- frame_start together with a DONE->IDLE transition is also ignored; the front end guarantees at least one bit time of gap.
- sample_point is ignored in LATCH and DONE.
- Only the low LEN bits of the snapshot are compared; upper bits are don't-care.

Latency: the final CRC bit's sample_point to crc_done is 1 clk.

Test Plan:
- Classic frame, DLC=8, datapath crc_value=15'h4B3A, CRC field driven 100101100111010 with 2 stuff bits inserted -> crc_sel=1, 15 compared bits, crc_done with crc_ok=1, crc_error=0.
- FD frame, DLC=10 -> crc_sel=2, 17 bits compared; FD, DLC=11 -> crc_sel=3, 21 bits compared; DLC=15 -> crc_sel=3.
- FD CRC-21, expected 21'h1ABCDE, received bit 20 flipped, 6 fixed stuff bits with is_stuff=1 -> exactly 21 compares, crc_error=1, crc_ok=0.
- SOF -> crc_init is high 1 clk with crc_on=0; crc_on=1 from the next clk; crc_on=0 one clk after data_end; snapshot taken in LATCH, and a crc_value change after LATCH does not affect the result.
- data_end arrives with no prior dlc_valid -> crc_done + crc_error=1 one clk after LATCH; crc_field never asserts.
- abort asserted in the same clk as the 10th CRC-15 bit -> next clk in IDLE, no crc_done. Reset asserted in FIELD -> all outputs 0 asynchronously. The following SOF gives a normal check.
